fir_mac_scheduler: RTL
======================

FIR_MAC_SCHEDULER -- requirements
Module: fir_mac_scheduler

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 8, number of FIR taps (2..64).
REQ-002 SHALL have parameter ACC_W, default 24+$clog2(NUM_TAPS), accumulator width.
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port din_valid  in  1 and din_ready  out  1, the sample handshake.
REQ-006 SHALL have port din  in  12  signed two's-complement input sample.
REQ-007 SHALL have port coeff_we  in  1, coeff_addr  in  $clog2(NUM_TAPS), and coeff_data  in  12 (signed), the coefficient write port.
REQ-008 SHALL have port busy  out  1, high whenever the FSM is not in IDLE.
REQ-009 SHALL have port mult_a  out  12 (sample operand) and mult_b  out  12 (coefficient operand), which drive the shared external 12x12 signed multiplier.
REQ-010 SHALL have port mult_p  in  24, the signed product returned combinationally in the same cycle.
REQ-011 SHALL have port dout_valid  out  1 and dout_ready  in  1, the result handshake.
REQ-012 SHALL have port dout  out  24, the signed filter output.

Function
REQ-013 SHALL implement the FSM states IDLE, MAC and DONE; din_ready = (state==IDLE).
REQ-014 SHALL, on IDLE with din_valid&din_ready, shift the delay line (x[k]<=x[k-1], x[0]<=din), clear acc and tap index, and go to MAC.
REQ-015 SHALL, in MAC at tap index i, drive mult_a=x[i] and mult_b=c[i], and perform acc<=acc+sign_extend(mult_p).
REQ-016 SHALL increment i every MAC cycle; after i==NUM_TAPS-1 the accumulate completes and the FSM goes to DONE (exactly NUM_TAPS MAC cycles).
REQ-017 SHALL drive mult_a and mult_b to 0 outside MAC.
REQ-018 SHALL, in DONE, hold dout_valid=1 and dout stable until dout_ready=1, then go to IDLE on that edge.
REQ-019 SHALL give a latency from the accept edge to the first dout_valid cycle of NUM_TAPS+1 cycles; with dout_ready held high, the minimum sample period is NUM_TAPS+2 cycles.
REQ-020 SHALL commit coeff_we writes only while in IDLE; writes while busy=1 are silently dropped.
REQ-021 SHALL, when a write and a sample accept occur on the same IDLE edge, commit both, and the resulting MAC uses the new coefficient.
REQ-022 SHALL ignore din_valid in MAC and DONE; the delay line is unchanged.
REQ-023 SHALL perform all arithmetic as signed; acc never wraps for legal NUM_TAPS at the default ACC_W.

Reset
REQ-024 SHALL, while rst is high at a clock edge, set: state=IDLE, delay line=0, coefficients=0, acc=0, index=0, dout=0, dout_valid=0.
REQ-025 SHALL, after reset, have din_ready=1 and busy=0.
REQ-026 SHALL treat reset during MAC or DONE as abandoning the result; no dout_valid is produced for it.

Configuration
REQ-027 SHALL, when FIR_SAT_EN is defined, saturate dout to the range [-8388608, 8388607] from acc.
REQ-028 SHALL, when FIR_SAT_EN is undefined, set dout=acc[23:0] (wrap).

Structure
REQ-029 SHALL place the following in a shared package fir_pkg: DATA_W=12, PROD_W=24, sample_t, coeff_t, prod_t, and the state enum fir_state_e.
REQ-030 SHALL place the delay line and coefficient register file in sub-module fir_tap_store, with a shift port, a write port and two indexed read ports; the FSM, accumulator and saturation logic stay in the top module.

Verification (NUM_TAPS=8, multiplier model attached)
REQ-031 SHALL cover: c[0]=1, others 0; din=100 -> dout=100, with dout_valid exactly 9 cycles after the accept edge.
REQ-032 SHALL cover: c[k]=k+1; inputs 1,0,0,0,0,0,0,0 -> outputs 1,2,3,4,5,6,7,8.
REQ-033 SHALL cover: c[0]=0xFFD (-3), din=0xFFB (-5) -> dout=15; c[0]=0x800, din=0x800 -> dout=4194304.
REQ-034 SHALL cover: all c=0x800, eight inputs of 0x800 -> eighth dout = 8388607 with FIR_SAT_EN, and 0 without.
REQ-035 SHALL cover: dout_ready low for 5 DONE cycles -> dout stable, din_ready=0, din_valid pulses ignored, and a coeff write issued then is dropped (readback via a subsequent impulse).
REQ-036 SHALL cover: rst at MAC index 3 -> next cycle state IDLE, dout_valid=0, and all-zero delay line; then c[0]=1 with din=7 -> dout=7.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types for the FIR MAC scheduler: operand/product widths, sample,
// coefficient and product types, and the scheduler state encoding.
package fir_pkg;

  localparam int DATA_W = 12;
  localparam int PROD_W = 24;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [DATA_W-1:0] coeff_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fir_state_e;

endpackage

// File: rtl/fir_tap_store.sv
// Delay line and coefficient register file for the FIR scheduler.
// One shift port, one coefficient write port, two indexed read ports.
module fir_tap_store
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = 8,
  parameter int AW       = $clog2(NUM_TAPS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          shift_i,
  input  sample_t       sample_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  coeff_t        wdata_i,
  input  logic [AW-1:0] xaddr_i,
  input  logic [AW-1:0] caddr_i,
  output sample_t       x_o,
  output coeff_t        c_o
);

  sample_t x_q [NUM_TAPS];
  coeff_t  c_q [NUM_TAPS];

  // Shift new sample into x[0]; commit coefficient writes; reset clears both.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        x_q[k] <= '0;
        c_q[k] <= '0;
      end
    end else begin
      if (shift_i) begin
        x_q[0] <= sample_i;
        for (int k = 1; k < NUM_TAPS; k++) x_q[k] <= x_q[k-1];
      end
      if (we_i) c_q[waddr_i] <= wdata_i;
    end
  end

  assign x_o = x_q[xaddr_i];
  assign c_o = c_q[caddr_i];

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR filter: one shared external 12x12 multiplier, one
// tap per cycle. Optional output saturation is enabled with FIR_SAT_EN;
// without it dout is the low 24 bits of the accumulator.
module fir_mac_scheduler
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = 8,
  parameter int ACC_W    = 24 + $clog2(NUM_TAPS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        din_valid,
  output logic                        din_ready,
  input  logic [11:0]                 din,
  input  logic                        coeff_we,
  input  logic [$clog2(NUM_TAPS)-1:0] coeff_addr,
  input  logic [11:0]                 coeff_data,
  output logic                        busy,
  output logic [11:0]                 mult_a,
  output logic [11:0]                 mult_b,
  input  logic [23:0]                 mult_p,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic [23:0]                 dout
);

  localparam int            AW   = $clog2(NUM_TAPS);
  localparam logic [AW-1:0] LAST = AW'(NUM_TAPS - 1);

  fir_state_e              state_q;
  logic [AW-1:0]           idx_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [23:0]             dout_q, dout_d;
  logic                    dout_valid_q;
  logic                    accept, coeff_commit;
  sample_t                 x_rd;
  coeff_t                  c_rd;

  assign accept       = (state_q == IDLE) && din_valid;
  // Coefficients may only change between samples so a MAC pass is consistent.
  assign coeff_commit = (state_q == IDLE) && coeff_we;

  fir_tap_store #(.NUM_TAPS(NUM_TAPS), .AW(AW)) u_store (
    .clk_i    (clk),
    .rst_i    (rst),
    .shift_i  (accept),
    .sample_i (sample_t'(din)),
    .we_i     (coeff_commit),
    .waddr_i  (coeff_addr),
    .wdata_i  (coeff_t'(coeff_data)),
    .xaddr_i  (idx_q),
    .caddr_i  (idx_q),
    .x_o      (x_rd),
    .c_o      (c_rd)
  );

  assign mult_a     = (state_q == MAC) ? x_rd : '0;
  assign mult_b     = (state_q == MAC) ? c_rd : '0;
  assign din_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;

  // Next accumulator value and the output word derived from it.
  always_comb begin
    acc_d = acc_q + $signed({{(ACC_W-PROD_W){mult_p[PROD_W-1]}}, mult_p});
`ifdef FIR_SAT_EN
    if (acc_d > $signed(ACC_W'(8388607)))
      dout_d = 24'h7F_FFFF;
    else if (acc_d < $signed(ACC_W'(-8388608)))
      dout_d = 24'h80_0000;
    else
      dout_d = acc_d[23:0];
`else
    dout_d = acc_d[23:0];
`endif
  end

  // Scheduler FSM: accept sample, run NUM_TAPS MAC cycles, hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      acc_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            dout_q       <= dout_d;
            dout_valid_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (dout_ready) begin
            dout_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
